lfsr_coin_gen: RTL

Parametrised multi-channel Fibonacci LFSR coin generator for the NTRU-HRSS random-sampling path. Each channel steps in lock-step, and every OUT_W steps the block publishes one fresh, non-overlapping OUT_W-bit word per channel on a valid/ready port. It adds runtime per-channel seeding, back-pressure stalling and all-zero lock-up recovery, and feeds the coin consumers (ternary/fixed-weight samplers).

---
 rtl/lfsr_coin_gen_if.sv | 22 ++
 rtl/lfsr_coin_gen.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lfsr_coin_gen_if.sv
// Coin word stream between lfsr_coin_gen (master) and a coin consumer (slave).
// Valid/ready handshake; channel c occupies coins[c*OUT_W +: OUT_W].
interface lfsr_coin_gen_if #(
    parameter int CHANNELS = 2,
    parameter int OUT_W    = 8
);
    logic [CHANNELS*OUT_W-1:0] coins;
    logic                      coins_valid;
    logic                      coins_ready;

    modport master (
        output coins,
        output coins_valid,
        input  coins_ready
    );

    modport slave (
        input  coins,
        input  coins_valid,
        output coins_ready
    );
endinterface

// File: rtl/lfsr_coin_gen.sv
// Multi-channel Fibonacci LFSR coin generator: one fresh OUT_W-bit word per channel every OUT_W steps.
// Optional macro LFSR_LOCKUP_GUARD_EN: all-zero channels recover to 1 and raise sticky lockup.
//
// state    | meaning
// ST_IDLE  | enable low, everything holds
// ST_RUN   | all channels step together
// ST_STALL | completing step blocked by back-pressure, channels and cnt hold
// ST_SEED  | seed write cycle, cnt cleared, no step
module lfsr_coin_gen #(
    parameter int                          WIDTH    = 8,
    parameter int                          CHANNELS = 2,
    parameter logic [WIDTH-1:0]            TAPS     = 8'hB8,
    parameter logic [CHANNELS*WIDTH-1:0]   SEED     = 16'h01FF,
    parameter int                          OUT_W    = 8,
    localparam int                         SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 seed_we,
    input  logic [SEL_W-1:0]     seed_ch,
    input  logic [WIDTH-1:0]     seed_data,
    lfsr_coin_gen_if.master      coin_bus,
    output logic                 lockup
);

    localparam int              CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_SEED  = 2'd3;

    logic [WIDTH-1:0]          lfsr_q       [CHANNELS];
    logic [WIDTH-1:0]          lfsr_stepped [CHANNELS];
    logic [CNT_W-1:0]          cnt;
    logic [CHANNELS*OUT_W-1:0] coins_q;
    logic [CHANNELS*OUT_W-1:0] coins_next;
    logic                      valid_q;
    logic [1:0]                mode;
    logic                      last_step;
    logic                      complete;

    assign last_step = (cnt == LAST);

    // The state is a pure function of this cycle's inputs and registered status,
    // so no path runs from coins_ready to the registered outputs.
    always_comb begin
        mode = ST_RUN;
        if (seed_we) begin
            mode = ST_SEED;
        end else if (!enable) begin
            mode = ST_IDLE;
        end else if (last_step && valid_q && !coin_bus.coins_ready) begin
            mode = ST_STALL;
        end
    end

    assign complete = (mode == ST_RUN) && last_step;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            lfsr_stepped[c] = {lfsr_q[c][WIDTH-2:0], ^(lfsr_q[c] & TAPS)};
`ifdef LFSR_LOCKUP_GUARD_EN
            if (lfsr_q[c] == '0) begin
                lfsr_stepped[c] = WIDTH'(1);
            end
`endif
        end
    end

    always_comb begin
        coins_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            coins_next[c*OUT_W +: OUT_W] = lfsr_stepped[c][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                lfsr_q[c] <= SEED[c*WIDTH +: WIDTH];
            end
            cnt     <= '0;
            coins_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (mode == ST_SEED) begin
                // Out-of-range channel numbers match nothing, so the write is dropped.
                for (int c = 0; c < CHANNELS; c++) begin
                    if (seed_ch == SEL_W'(c)) begin
                        lfsr_q[c] <= seed_data;
                    end
                end
                cnt <= '0;
            end else if (mode == ST_RUN) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    lfsr_q[c] <= lfsr_stepped[c];
                end
                cnt <= last_step ? '0 : cnt + 1'b1;
            end

            if (complete) begin
                coins_q <= coins_next;
                valid_q <= 1'b1;
            end else if (valid_q && coin_bus.coins_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign coin_bus.coins       = coins_q;
    assign coin_bus.coins_valid = valid_q;

`ifdef LFSR_LOCKUP_GUARD_EN
    logic [CHANNELS-1:0] zero_hit;
    logic                lock_q;

    always_comb begin
        zero_hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            zero_hit[c] = (lfsr_q[c] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q <= 1'b0;
        end else if ((mode == ST_RUN) && (|zero_hit)) begin
            lock_q <= 1'b1;
        end
    end

    assign lockup = lock_q;
`else
    assign lockup = 1'b0;
`endif

endmodule
